// File: rtl/bg_noise_estimator.sv
`default_nettype none
// ============================================================================
// Module   : bg_noise_estimator
// Brief    : 16-lane background-noise estimator averaging 2**LOG2_PERIODS periods.
// Revision : 1.0 - initial release
// ============================================================================
module bg_noise_estimator #(
    parameter int LOG2_PERIODS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] PeriodData,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] BgNoise,
    output logic         bg_valid,
    output logic         done
);

    localparam int c_acc_w = 8 + LOG2_PERIODS;
    localparam logic [LOG2_PERIODS-1:0] c_cnt_one = LOG2_PERIODS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_clear;
    logic   w_accum;
    logic   w_complete;

    logic [LOG2_PERIODS-1:0]   r_cnt;
    logic signed [c_acc_w-1:0] r_acc [16];
    logic signed [c_acc_w-1:0] w_sum [16];
    logic signed [c_acc_w-1:0] w_shr [16];
    logic signed [15:0]        w_avg [16];

    // The average is taken from the running sum plus the completing transfer,
    // so the result is ready one cycle after the last handshake.
    for (genvar g = 0; g < 16; g++) begin : g_lane
        logic signed [7:0] w_lane;
        assign w_lane   = PeriodData[8*g +: 8];
        assign w_sum[g] = r_acc[g] + c_acc_w'(w_lane);
        assign w_shr[g] = w_sum[g] >>> LOG2_PERIODS;
        assign w_avg[g] = 16'(w_shr[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            in_ready <= 1'b0;
        end else begin
            r_state  <= w_next;
            in_ready <= (w_next == S_ACCUM);
        end
    end

    // start outranks a transfer, including the completing one.
    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_accum    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next  = S_ACCUM;
                    w_clear = 1'b1;
                end
            end
            S_ACCUM: begin
                if (start) begin
                    w_clear = 1'b1;
                end else if (in_valid) begin
                    w_accum = 1'b1;
                    if (&r_cnt) begin
                        w_complete = 1'b1;
                        w_next     = S_DONE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            BgNoise  <= '0;
            bg_valid <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            done <= w_complete;
            if (w_clear) begin
                r_cnt <= '0;
                for (int i = 0; i < 16; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_accum) begin
                r_cnt <= r_cnt + c_cnt_one;
                for (int i = 0; i < 16; i++) begin
                    r_acc[i] <= w_sum[i];
                end
            end
            if (w_complete) begin
                bg_valid <= 1'b1;
                for (int i = 0; i < 16; i++) begin
                    BgNoise[16*i +: 16] <= w_avg[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bg_noise_estimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg_noise_estimator
// Brief    : Directed and randomized bench with a per-period averaging model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bg_noise_estimator;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic [127:0] PeriodData;
    logic         in_ready;
    logic [255:0] BgNoise;
    logic         bg_valid;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    // Model: phase 0 = idle, 1 = accumulating, 2 = estimate complete.
    int m_phase;
    int m_cnt;
    int m_sum   [16];
    int m_noise [16];
    bit m_bgv;
    bit m_done;

    bg_noise_estimator #(.LOG2_PERIODS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .PeriodData (PeriodData),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .BgNoise    (BgNoise),
        .bg_valid   (bg_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [127:0] fill(int v);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(v);
        return d;
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function void model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_bgv   = 1'b0;
        m_done  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_sum[i]   = 0;
            m_noise[i] = 0;
        end
    endfunction

    function void model_clear();
        m_cnt = 0;
        for (int i = 0; i < 16; i++) m_sum[i] = 0;
    endfunction

    function void model_edge(bit s, bit v, logic [127:0] d);
        byte b;
        m_done = 1'b0;
        if (m_phase != 1) begin
            if (s) begin
                m_phase = 1;
                model_clear();
            end
        end else if (s) begin
            model_clear();
        end else if (v) begin
            for (int i = 0; i < 16; i++) begin
                b = d[8*i +: 8];
                m_sum[i] += int'(b);
            end
            m_cnt++;
            if (m_cnt == N) begin
                for (int i = 0; i < 16; i++) m_noise[i] = floor_div(m_sum[i], N);
                m_bgv   = 1'b1;
                m_done  = 1'b1;
                m_phase = 2;
            end
        end
    endfunction

    task automatic check(string tag);
        logic [255:0] exp_noise;
        for (int i = 0; i < 16; i++) exp_noise[16*i +: 16] = 16'(m_noise[i]);
        vectors++;
        assert (in_ready === (m_phase == 1)) else begin
            miscompares++;
            $error("FAIL %s in_ready got %b exp %b", tag, in_ready, (m_phase == 1));
        end
        vectors++;
        assert (done === m_done) else begin
            miscompares++;
            $error("FAIL %s done got %b exp %b", tag, done, m_done);
        end
        vectors++;
        assert (bg_valid === m_bgv) else begin
            miscompares++;
            $error("FAIL %s bg_valid got %b exp %b", tag, bg_valid, m_bgv);
        end
        vectors++;
        assert (BgNoise === exp_noise) else begin
            miscompares++;
            $error("FAIL %s BgNoise got %h exp %h", tag, BgNoise, exp_noise);
        end
    endtask

    // Drive just after the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(string tag, bit s, bit v, logic [127:0] d);
        start      = s;
        in_valid   = v;
        PeriodData = d;
        model_edge(s, v, d);
        @(posedge clk);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    task automatic check_lane(string tag, int lane, logic [15:0] exp);
        vectors++;
        assert (BgNoise[16*lane +: 16] === exp) else begin
            miscompares++;
            $error("FAIL %s lane %0d got %h exp %h", tag, lane, BgNoise[16*lane +: 16], exp);
        end
    endtask

    initial begin
        logic [127:0] d;
        int hs;
        int budget;

        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        PeriodData = '0;
        model_reset();
        #2;
        check("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp: lane i = 5*i, back-to-back; start on the first edge after release.
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(5 * i);
        cycle("ramp_start", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) cycle("ramp", 1'b0, 1'b1, d);
        check_lane("ramp", 15, 16'h004B);

        // Extremes: start issued while done is high.
        cycle("ext_start", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) begin
            d = fill(0);
            d[7:0]   = (k % 2 == 0) ? 8'hFF : 8'hFE;
            d[15:8]  = 8'h80;
            d[23:16] = 8'h7F;
            cycle("ext", 1'b0, 1'b1, d);
        end
        check_lane("ext", 0, 16'hFFFE);
        check_lane("ext", 1, 16'hFF80);
        check_lane("ext", 2, 16'h007F);

        // Gapped handshakes of 3; garbage on the bus during gaps.
        cycle("gap_start", 1'b1, 1'b0, '0);
        hs = 0;
        budget = 0;
        while (hs < N && budget < 200) begin
            if ($urandom_range(0, 1) == 1) begin
                cycle("gap", 1'b0, 1'b1, fill(3));
                hs++;
            end else begin
                cycle("gap_idle", 1'b0, 1'b0, rand_data());
            end
            budget++;
        end
        vectors++;
        assert (hs == N) else begin
            miscompares++;
            $error("FAIL gap_budget handshakes got %0d exp %0d", hs, N);
        end
        check_lane("gap", 7, 16'h0003);

        // Restart mid-accumulation: estimate of 3 must hold until -4 completes.
        cycle("rst_start", 1'b1, 1'b0, '0);
        for (int k = 0; k < 7; k++) cycle("part10", 1'b0, 1'b1, fill(10));
        cycle("restart", 1'b1, 1'b1, fill(10));
        for (int k = 0; k < N; k++) cycle("neg4", 1'b0, 1'b1, fill(-4));
        check_lane("neg4", 9, 16'hFFFC);
        cycle("neg4_after", 1'b0, 1'b1, fill(5));

        // start coincident with the completing transfer discards it.
        cycle("coinc_start", 1'b1, 1'b0, '0);
        for (int k = 0; k < N - 1; k++) cycle("coinc", 1'b0, 1'b1, fill(20));
        cycle("coinc_16th", 1'b1, 1'b1, fill(20));
        for (int k = 0; k < N; k++) cycle("coinc_more", 1'b0, 1'b1, fill(-7));

        // Asynchronous reset between edges after 9 transfers.
        cycle("ar_start", 1'b1, 1'b0, '0);
        for (int k = 0; k < 9; k++) cycle("ar_part", 1'b0, 1'b1, fill(50));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("ar_idle", 1'b0, 1'b1, fill(9));
        cycle("ar_go", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) cycle("ones", 1'b0, 1'b1, fill(1));
        check_lane("ones", 4, 16'h0001);

        // Random traffic with occasional restarts.
        for (int k = 0; k < 600; k++) begin
            cycle("random", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), rand_data());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bg_noise_estimator.md
BG_NOISE_ESTIMATOR -- requirements
Module: bg_noise_estimator

Interface
REQ-001 Parameter: LOG2_PERIODS, default 4, log2 of the number of periods N averaged per estimate (legal 1..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  single-cycle pulse; begins a new estimate.
REQ-005 PeriodData  input  128  16 lanes; lane i = bits [8i+7:8i], signed 8-bit.
REQ-006 in_valid  input  1  PeriodData valid this cycle.
REQ-007 in_ready  output  1  block accepts PeriodData this cycle.
REQ-008 BgNoise  output  256  16 lanes; lane i = bits [16i+15:16i], signed 16-bit per-lane average noise.
REQ-009 bg_valid  output  1  BgNoise holds a completed estimate.
REQ-010 done  output  1  one-cycle pulse on estimate completion.

Function
REQ-011 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-012 IDLE and DONE: in_ready=0; start moves the block to ACCUM next cycle, clearing all 16 accumulators and the period counter.
REQ-013 ACCUM: in_ready=1; a transfer occurs only when in_valid and in_ready are both high in the same cycle.
REQ-014 On each transfer, every lane accumulator SHALL add its sign-extended lane value; accumulator width 8+LOG2_PERIODS bits, signed, no overflow possible.
REQ-015 The period counter SHALL count transfers only; in_valid gaps SHALL leave accumulators and counter unchanged.
REQ-016 On the Nth transfer (N = 2**LOG2_PERIODS), the next cycle SHALL present BgNoise lane i = (sum_i + lane_i of that transfer) arithmetically shifted right by LOG2_PERIODS (floor toward minus infinity), sign-extended to 16 bits.
REQ-017 In that same cycle bg_valid SHALL be 1, done SHALL pulse for exactly one cycle, and the state SHALL be DONE with in_ready=0.
REQ-018 BgNoise and bg_valid SHALL update only on completion; during a subsequent ACCUM they SHALL hold the previous estimate unchanged.
REQ-019 start asserted in ACCUM SHALL restart: accumulators and counter cleared, and any transfer in that cycle discarded; start has priority over a transfer.
REQ-020 start coincident with the completing (Nth) transfer SHALL discard the completion: no done pulse, BgNoise unchanged, ACCUM restarted.
REQ-021 start in DONE the cycle done is high SHALL be accepted normally (ACCUM next cycle).
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs except none (in_ready depends on state only).

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, in_ready=0, BgNoise=0, bg_valid=0, done=0, accumulators=0, counter=0.
REQ-024 Reset mid-ACCUM SHALL discard the partial estimate; after release the block waits in IDLE for start.
REQ-025 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-026 Default parameter; start; 16 back-to-back transfers, lane i = 5*i -> done pulse one cycle after 16th transfer, BgNoise lane i = 5*i (lane 15 = 0x004B), bg_valid=1, in_ready=0.
REQ-027 16 transfers, lane 0 alternating -1/-2, lane 1 constant -128, lane 2 constant 127 -> lane 0 = -2 (0xFFFE), lane 1 = 0xFF80, lane 2 = 0x007F.
REQ-028 in_valid toggled pseudo-randomly over 40 cycles with 16 handshakes of constant 3 -> completion exactly one cycle after 16th handshake, all lanes = 3; no extra accumulation during gaps.
REQ-029 Prior estimate all lanes 3; start; 7 transfers of 10; start again; 16 transfers of -4 -> BgNoise stays 3 until completion, then all lanes -4 (0xFFFC); one done pulse only.
REQ-030 Reset asserted asynchronously (between edges) after 9 transfers -> all outputs 0 immediately; after release, start plus 16 transfers of 1 -> all lanes 1.
REQ-031 start coincident with 16th transfer -> no done, bg_valid/BgNoise unchanged, in_ready stays 1 and 16 further transfers are required for completion.
